// File: rtl/uart_cmd_link.sv
// uart_cmd_link: host-side 8N1 UART front end for the DSO core.
//   Collects three received bytes into a 24-bit command (cmd_rdy/clr_cmd_rdy
//   handshake) and transmits single response bytes (trmt/tx_done handshake).
//   RX and TX run independently (full duplex).
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   RX              asynchronous serial input, idle high
//   cmd[23:0]       assembled command, first byte in [23:16]
//   cmd_rdy         complete command valid
//   clr_cmd_rdy     consumer acknowledge, clears cmd_rdy
//   tx_data[7:0]    response byte, captured on trmt
//   trmt            one-cycle send request (ignored while tx_busy)
//   TX              serial output, idle high
//   tx_done         sticky, set when the stop bit has completed
//   tx_busy         transmitter active
//   frame_err       one-cycle pulse, received stop bit was 0
//   overrun         one-cycle pulse, byte dropped while cmd_rdy was high
//
// Optional feature: define UART_CMD_TIMEOUT_EN to discard a partial command
// after TIMEOUT_CLKS idle cycles between bytes.
module uart_cmd_link #(
    parameter int unsigned BAUD_DIV     = 347,
    parameter logic [19:0] TIMEOUT_CLKS = 20'd400000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  tx_data,
    input  logic        trmt,
    output logic        TX,
    output logic        tx_done,
    output logic        tx_busy,
    output logic        frame_err,
    output logic        overrun
);

    localparam int unsigned     CNT_W     = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

    // ------------------------------------------------------------------
    // RX synchronizer
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    rx_state_t        rx_state;
    rx_state_t        rx_state_nxt;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_wait;          // bad stop bit seen, waiting for line high
    logic             rx_load_half_c;
    logic             rx_load_full_c;
    logic             rx_shift_c;
    logic             rx_byte_ok_c;
    logic             rx_frame_bad_c;

    // Next state and per-cycle strobes
    always_comb begin
        rx_state_nxt   = rx_state;
        rx_load_half_c = 1'b0;
        rx_load_full_c = 1'b0;
        rx_shift_c     = 1'b0;
        rx_byte_ok_c   = 1'b0;
        rx_frame_bad_c = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    rx_load_half_c = 1'b1;
                    rx_state_nxt   = RX_START;
                end
            end
            RX_START: begin
                // Mid-start-bit re-check rejects glitches
                if (rx_cnt == '0) begin
                    if (rx_sync) begin
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        rx_load_full_c = 1'b1;
                        rx_state_nxt   = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (rx_cnt == '0) begin
                    rx_shift_c     = 1'b1;
                    rx_load_full_c = 1'b1;
                    if (rx_bit == 3'd7) begin
                        rx_state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_wait) begin
                    if (rx_sync) begin
                        rx_state_nxt = RX_IDLE;
                    end
                end else if (rx_cnt == '0) begin
                    if (rx_sync) begin
                        rx_byte_ok_c = 1'b1;
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        rx_frame_bad_c = 1'b1;
                    end
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // RX state, baud counter and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_wait  <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            if (rx_load_half_c) begin
                rx_cnt <= HALF_LOAD;
            end else if (rx_load_full_c) begin
                rx_cnt <= FULL_LOAD;
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - CNT_W'(1);
            end
            if (rx_load_half_c) begin
                rx_bit <= '0;
            end else if (rx_shift_c) begin
                rx_bit <= rx_bit + 3'd1;
            end
            if (rx_shift_c) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
            end
            if (rx_frame_bad_c) begin
                rx_wait <= 1'b1;
            end else if (rx_state_nxt == RX_IDLE) begin
                rx_wait <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Inter-byte timeout
    // ------------------------------------------------------------------
    logic [1:0] byte_cnt;
    logic       timeout_c;

`ifdef UART_CMD_TIMEOUT_EN
    logic [19:0] gap_cnt;

    assign timeout_c = (rx_state == RX_IDLE) && (byte_cnt != 2'd0)
                       && (gap_cnt == TIMEOUT_CLKS - 20'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (rx_state != RX_IDLE || byte_cnt == 2'd0 || rx_load_half_c || timeout_c) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + 20'd1;
        end
    end
`else
    logic unused_timeout;

    assign timeout_c      = 1'b0;
    assign unused_timeout = ^TIMEOUT_CLKS;
`endif

    // ------------------------------------------------------------------
    // Command assembly and cmd_rdy handshake
    // ------------------------------------------------------------------
    logic cmd_set_c;

    assign cmd_set_c = rx_byte_ok_c && !cmd_rdy && (byte_cnt == 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd       <= '0;
            cmd_rdy   <= 1'b0;
            byte_cnt  <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= rx_frame_bad_c;
            overrun   <= rx_byte_ok_c && cmd_rdy;
            if (rx_frame_bad_c) begin
                byte_cnt <= '0;
            end else if (rx_byte_ok_c && !cmd_rdy) begin
                case (byte_cnt)
                    2'd0:    cmd[23:16] <= rx_shift;
                    2'd1:    cmd[15:8]  <= rx_shift;
                    default: cmd[7:0]   <= rx_shift;
                endcase
                byte_cnt <= (byte_cnt == 2'd2) ? 2'd0 : byte_cnt + 2'd1;
            end else if (timeout_c) begin
                byte_cnt <= '0;
            end
            // Set has priority over a same-cycle clear
            if (cmd_set_c) begin
                cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    tx_state_t        tx_state;
    tx_state_t        tx_state_nxt;
    logic [9:0]       tx_frame;         // bit 0 is the line value
    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_bit;
    logic             tx_start_c;
    logic             tx_next_c;
    logic             tx_end_c;

    assign TX = tx_frame[0];

    // Next state and per-cycle strobes
    always_comb begin
        tx_state_nxt = tx_state;
        tx_start_c   = 1'b0;
        tx_next_c    = 1'b0;
        tx_end_c     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (trmt) begin
                    tx_start_c   = 1'b1;
                    tx_state_nxt = TX_XMIT;
                end
            end
            TX_XMIT: begin
                if (tx_cnt == '0) begin
                    if (tx_bit == 4'd9) begin
                        tx_end_c     = 1'b1;
                        tx_state_nxt = TX_IDLE;
                    end else begin
                        tx_next_c = 1'b1;
                    end
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // TX state, frame shifter and handshake flags
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_frame <= '1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            if (tx_start_c) begin
                tx_frame <= {1'b1, tx_data, 1'b0};
                tx_cnt   <= FULL_LOAD;
                tx_bit   <= '0;
                tx_busy  <= 1'b1;
                tx_done  <= 1'b0;
            end else if (tx_next_c) begin
                tx_frame <= {1'b1, tx_frame[9:1]};
                tx_cnt   <= FULL_LOAD;
                tx_bit   <= tx_bit + 4'd1;
            end else if (tx_end_c) begin
                tx_frame <= '1;
                tx_busy  <= 1'b0;
                tx_done  <= 1'b1;
            end else if (tx_cnt != '0) begin
                tx_cnt <= tx_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_link.sv
// Directed testbench for uart_cmd_link: command assembly, cmd_rdy handshake,
// TX framing/timing, frame error, overrun, reset mid-frame and inter-byte
// timeout (expected result depends on UART_CMD_TIMEOUT_EN).
module tb_uart_cmd_link;

    localparam int unsigned BAUD = 347;
    localparam int unsigned GAP  = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        RX;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        TX;
    logic        tx_done;
    logic        tx_busy;
    logic        frame_err;
    logic        overrun;

    int tests = 0;
    int fails = 0;

    // Flags captured around the stop-bit sample of the last byte sent
    logic rdy_b, rdy_a, rdy_a2;
    logic ferr_a, ferr_a2;
    logic ovr_a, ovr_a2;

    // Expected TX line, bit 0 first: start, A5 LSB first, stop
    logic [9:0] exp_tx = 10'b1101001010;

    uart_cmd_link #(
        .BAUD_DIV     (BAUD),
        .TIMEOUT_CLKS (20'd5000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (RX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .tx_data     (tx_data),
        .trmt        (trmt),
        .TX          (TX),
        .tx_done     (tx_done),
        .tx_busy     (tx_busy),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one 8N1 frame starting at the current negedge. The stop-bit
    // sample lands on the edge after negedge n0+3298, so flags are captured
    // just before it and on the two negedges after it.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic clr_at_stop);
        RX = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BAUD) @(negedge clk);
        end
        RX = stop_bit;
        repeat (175) @(negedge clk);
        rdy_b = cmd_rdy;
        if (clr_at_stop) clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        rdy_a  = cmd_rdy;
        ferr_a = frame_err;
        ovr_a  = overrun;
        @(negedge clk);
        rdy_a2  = cmd_rdy;
        ferr_a2 = frame_err;
        ovr_a2  = overrun;
        repeat (BAUD - 177) @(negedge clk);
        RX = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        logic [23:0] exp_to;
        rst         = 1'b1;
        RX          = 1'b1;
        clr_cmd_rdy = 1'b0;
        tx_data     = 8'h00;
        trmt        = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_TX", TX, 1'b1);
        check("rst_cmd", cmd, 24'h0);
        check("rst_cmd_rdy", cmd_rdy, 1'b0);
        check("rst_tx_done", tx_done, 1'b0);
        check("rst_tx_busy", tx_busy, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        repeat (5) @(negedge clk);

        // Basic 3-byte command
        send_byte(8'h01, 1'b1, 1'b0);
        send_byte(8'h23, 1'b1, 1'b0);
        check("partial_no_rdy", cmd_rdy, 1'b0);
        send_byte(8'h45, 1'b1, 1'b0);
        check("rdy_before_stop", rdy_b, 1'b0);
        check("rdy_after_stop", rdy_a, 1'b1);
        check("cmd_012345", cmd, 24'h012345);
        pulse_clr();
        check("clr_drops_rdy", cmd_rdy, 1'b0);
        check("cmd_held", cmd, 24'h012345);

        // Transmit A5 with an ignored second trmt at cycle 100
        tx_data = 8'hA5;
        trmt    = 1'b1;
        for (int c = 1; c <= 3471; c++) begin
            @(negedge clk);
            if (c == 1) trmt = 1'b0;
            if (c == 100) begin
                tx_data = 8'h00;
                trmt    = 1'b1;
            end
            if (c == 101) begin
                trmt = 1'b0;
                check("tx_busy_mid", tx_busy, 1'b1);
            end
            if (c <= 3470 && (((c - 1) % BAUD) == 0 || (c % BAUD) == 0))
                check("tx_bit", TX, exp_tx[(c - 1) / BAUD]);
            if (c == 3470) begin
                check("tx_done_early", tx_done, 1'b0);
                check("tx_busy_last", tx_busy, 1'b1);
            end
            if (c == 3471) begin
                check("tx_done", tx_done, 1'b1);
                check("tx_busy_end", tx_busy, 1'b0);
                check("tx_idle_high", TX, 1'b1);
            end
        end
        repeat (50) @(negedge clk);
        check("tx_done_sticky", tx_done, 1'b1);

        // Frame error then a clean command
        send_byte(8'h55, 1'b0, 1'b0);
        check("frame_err_pulse", ferr_a, 1'b1);
        check("frame_err_end", ferr_a2, 1'b0);
        check("ferr_no_rdy", rdy_a, 1'b0);
        send_byte(8'hAA, 1'b1, 1'b0);
        send_byte(8'hBB, 1'b1, 1'b0);
        send_byte(8'hCC, 1'b1, 1'b0);
        check("cmd_aabbcc", cmd, 24'hAABBCC);
        check("rdy_aabbcc", cmd_rdy, 1'b1);

        // Overrun: byte arrives while cmd_rdy is still high
        send_byte(8'h77, 1'b1, 1'b0);
        check("overrun_pulse", ovr_a, 1'b1);
        check("overrun_end", ovr_a2, 1'b0);
        check("overrun_cmd", cmd, 24'hAABBCC);
        check("overrun_rdy", cmd_rdy, 1'b1);
        pulse_clr();

        // Reset mid-TX and mid-RX of byte two
        send_byte(8'h10, 1'b1, 1'b0);
        check("byte1_written", cmd, 24'h10BBCC);
        tx_data = 8'h3C;
        trmt    = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        RX   = 1'b0;
        repeat (600) @(negedge clk);
        check("pre_rst_busy", tx_busy, 1'b1);
        rst = 1'b1;
        RX  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_TX", TX, 1'b1);
        check("mid_rst_busy", tx_busy, 1'b0);
        check("mid_rst_rdy", cmd_rdy, 1'b0);
        check("mid_rst_cmd", cmd, 24'h0);
        check("mid_rst_done", tx_done, 1'b0);
        repeat (400) @(negedge clk);
        check("post_rst_TX", TX, 1'b1);

        // Fresh command; clear coincides with third-byte completion
        send_byte(8'h9A, 1'b1, 1'b0);
        send_byte(8'hBC, 1'b1, 1'b0);
        send_byte(8'hDE, 1'b1, 1'b1);
        check("set_wins_before", rdy_b, 1'b0);
        check("set_wins", rdy_a, 1'b1);
        check("set_wins_hold", rdy_a2, 1'b1);
        check("cmd_9abcde", cmd, 24'h9ABCDE);
        pulse_clr();

        // Inter-byte gap longer than the timeout
        send_byte(8'h11, 1'b1, 1'b0);
        repeat (6000) @(negedge clk);
        send_byte(8'h22, 1'b1, 1'b0);
        send_byte(8'h33, 1'b1, 1'b0);
        send_byte(8'h44, 1'b1, 1'b0);
`ifdef UART_CMD_TIMEOUT_EN
        exp_to = 24'h223344;
`else
        exp_to = 24'h112233;
`endif
        check("timeout_cmd", cmd, exp_to);
        check("timeout_rdy", cmd_rdy, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
